// File: rtl/axis_perf_monitor_mc.sv
// rtl/axis_perf_monitor_mc.sv - passive multi-channel AXIS performance monitor
// Per-channel beat/packet/byte/stall counters, shared window cycle count, registered readback.
module axis_perf_monitor_mc #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 512,
  parameter int CNT_W  = 32,
  localparam int KEEP_W = DATA_W / 8,
  localparam int RD_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_CH-1:0]        mon_tvalid,
  input  logic [NUM_CH-1:0]        mon_tready,
  input  logic [NUM_CH-1:0]        mon_tlast,
  input  logic [NUM_CH*KEEP_W-1:0] mon_tkeep,
  input  logic                     ctrl_start,
  input  logic                     ctrl_stop,
  input  logic                     ctrl_clear,
  input  logic [CNT_W-1:0]         pkt_target,
  input  logic [RD_W-1:0]          rd_ch,
  input  logic [2:0]               rd_sel,
  output logic [CNT_W-1:0]         rd_data,
  output logic [1:0]               mon_state,
  output logic                     mon_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic             r_done;
  logic [CNT_W-1:0] r_data;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_beats  [NUM_CH];
  logic [CNT_W-1:0] r_pkts   [NUM_CH];
  logic [CNT_W-1:0] r_bytes  [NUM_CH];
  logic [CNT_W-1:0] r_stalls [NUM_CH];

  logic [NUM_CH-1:0] w_hs;
  logic [NUM_CH-1:0] w_stall;
  logic [NUM_CH-1:0] w_reached;
  logic              w_all_hit;
  logic [CNT_W-1:0]  w_beats_nxt  [NUM_CH];
  logic [CNT_W-1:0]  w_pkts_nxt   [NUM_CH];
  logic [CNT_W-1:0]  w_bytes_nxt  [NUM_CH];
  logic [CNT_W-1:0]  w_stalls_nxt [NUM_CH];
  logic [CNT_W-1:0]  w_rd_nxt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // Channels that hit a nonzero target hold every counter; all_hit looks at post-update pkts.
  always_comb begin
    w_all_hit = (r_target != '0);
    for (int i = 0; i < NUM_CH; i++) begin
      w_hs[i]         = mon_tvalid[i] & mon_tready[i];
      w_stall[i]      = mon_tvalid[i] & ~mon_tready[i];
      w_reached[i]    = (r_target != '0) && (r_pkts[i] == r_target);
      w_beats_nxt[i]  = r_beats[i];
      w_pkts_nxt[i]   = r_pkts[i];
      w_bytes_nxt[i]  = r_bytes[i];
      w_stalls_nxt[i] = r_stalls[i];
      if (!w_reached[i]) begin
        w_beats_nxt[i]  = sat_add(r_beats[i], CNT_W'(w_hs[i]));
        w_pkts_nxt[i]   = sat_add(r_pkts[i], CNT_W'(w_hs[i] & mon_tlast[i]));
        w_bytes_nxt[i]  = sat_add(r_bytes[i],
                                  w_hs[i] ? CNT_W'($countones(mon_tkeep[i*KEEP_W +: KEEP_W])) : '0);
        w_stalls_nxt[i] = sat_add(r_stalls[i], CNT_W'(w_stall[i]));
      end
      if (w_pkts_nxt[i] != r_target) w_all_hit = 1'b0;
    end
  end

  always_comb begin
    w_rd_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == RD_W'(i)) begin
        case (rd_sel)
          3'd0:    w_rd_nxt = r_beats[i];
          3'd1:    w_rd_nxt = r_pkts[i];
          3'd2:    w_rd_nxt = r_bytes[i];
          3'd3:    w_rd_nxt = r_stalls[i];
          default: ;
        endcase
      end
    end
    if (rd_sel == 3'd4) w_rd_nxt = r_cycles;
    if (rd_sel == 3'd5) w_rd_nxt = CNT_W'(w_reached);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_cycles <= '0;
      r_target <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_beats[i]  <= '0;
        r_pkts[i]   <= '0;
        r_bytes[i]  <= '0;
        r_stalls[i] <= '0;
      end
    end else begin
      r_data <= w_rd_nxt;
      if (ctrl_clear || ctrl_start) begin
        r_state  <= ctrl_clear ? S_IDLE : S_ARMED;
        r_done   <= 1'b0;
        r_target <= ctrl_clear ? '0 : pkt_target;
        r_cycles <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          r_beats[i]  <= '0;
          r_pkts[i]   <= '0;
          r_bytes[i]  <= '0;
          r_stalls[i] <= '0;
        end
      end else if (r_state == S_ARMED || r_state == S_RUN) begin
        for (int i = 0; i < NUM_CH; i++) begin
          r_beats[i]  <= w_beats_nxt[i];
          r_pkts[i]   <= w_pkts_nxt[i];
          r_bytes[i]  <= w_bytes_nxt[i];
          r_stalls[i] <= w_stalls_nxt[i];
        end
        if (r_state == S_ARMED) begin
          // The first handshake opens the window and is itself cycle 1.
          if (|w_hs) begin
            r_cycles <= CNT_W'(1);
            r_state  <= S_RUN;
          end
          if (ctrl_stop) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end else begin
          r_cycles <= sat_add(r_cycles, CNT_W'(1));
          if (ctrl_stop || w_all_hit) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  assign rd_data   = r_data;
  assign mon_state = r_state;
  assign mon_done  = r_done;

endmodule

// File: doc/axis_perf_monitor_mc.md
# axis_perf_monitor_mc

Multi-channel passive AXI-Stream performance monitor for the XDMA/UDP perf-test designs. It taps `NUM_CH` AXIS links without driving any of them, and measures per-channel beats, packets, bytes and backpressure stall cycles, plus one shared measurement-window cycle count. Software, ILA or VIO reads the results through a registered select-mux. It generalises the fixed single-direction 32-bit TX/RX counters to N channels, a parametrised data width, a packet-target auto-stop and saturating counters.

## Interface
Parameters:
- `NUM_CH`, 2, number of monitored AXIS channels (1..8)
- `DATA_W`, 512, AXIS tdata width; `KEEP_W = DATA_W/8`
- `CNT_W`, 32, width of every counter and of `pkt_target`

Ports:
- `CLK`  in  1  single clock, all logic on rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `mon_tvalid`  in  NUM_CH  per-channel tvalid (tap)
- `mon_tready`  in  NUM_CH  per-channel tready (tap)
- `mon_tlast`  in  NUM_CH  per-channel tlast (tap)
- `mon_tkeep`  in  NUM_CH*KEEP_W  per-channel tkeep; channel i is bits [i*KEEP_W +: KEEP_W]
- `ctrl_start`  in  1  single-cycle pulse: clear counters and arm
- `ctrl_stop`  in  1  single-cycle pulse: end the window
- `ctrl_clear`  in  1  single-cycle pulse: return to IDLE and zero everything
- `pkt_target`  in  CNT_W  per-channel packet count for auto-stop; 0 = unlimited; sampled on start
- `rd_ch`  in  clog2(NUM_CH) (min 1)  channel select for readback
- `rd_sel`  in  3  counter select for readback
- `rd_data`  out  CNT_W  registered readback value
- `mon_state`  out  2  0 IDLE, 1 ARMED, 2 RUN, 3 DONE
- `mon_done`  out  1  high while in DONE

## Operation
- Handshake on channel i: `hs[i] = mon_tvalid[i] & mon_tready[i]`. Stall on channel i: `mon_tvalid[i] & ~mon_tready[i]`.
- Per-channel counters:
  - `beats` +1 per handshake.
  - `pkts` +1 per handshake with tlast.
  - `bytes` + popcount(tkeep) per handshake.
  - `stalls` +1 per stall cycle.
- Global counter `cycles`.
- All counters saturate at 2^CNT_W−1 and never wrap.
- Counting is governed by the current state. Counters update only in ARMED or RUN.
- A channel whose `pkts` has reached a nonzero target stops updating all of its counters.
- State machine:
  - IDLE: on `ctrl_start`, zero all counters, latch `pkt_target`, go to ARMED.
  - ARMED: `cycles` holds at 0. The first cycle with any `hs` bit counts that beat, sets `cycles=1` and goes to RUN. Stall cycles in ARMED count. `ctrl_stop` goes to DONE.
  - RUN: `cycles` +1 every cycle. `ctrl_stop` goes to DONE. If target ≠ 0 and every channel's `pkts` equals target after this cycle's update, go to DONE.
  - DONE: all counters frozen. `ctrl_start` re-arms exactly as from IDLE.
- Priority: `ctrl_clear` > `ctrl_start` > `ctrl_stop` > auto-stop.
  - `ctrl_clear` in any state: go to IDLE, zero all counters.
  - `ctrl_start` in ARMED or RUN restarts: zero counters, go to ARMED. Beats in that cycle are discarded.
- Stop and beat in the same RUN cycle: the beat is counted, `cycles` increments, next state is DONE.
- Readback `rd_sel`: 0 beats[rd_ch], 1 pkts[rd_ch], 2 bytes[rd_ch], 3 stalls[rd_ch], 4 cycles (rd_ch ignored), 5 zero-extended per-channel "target reached" bitmap, 6–7 return 0. `rd_ch ≥ NUM_CH` with sel 0–3 returns 0.

## Timing
- Reset (`RST_N` low, asynchronous) sets:
  - `rd_data=0`, `mon_state=0` (IDLE), `mon_done=0`
  - all counters 0, latched target 0
- Control pulses take effect on the edge where they are sampled. `mon_state` and `mon_done` reflect the new state the following cycle.
- Counter updates are visible at the next edge after the handshake.
- `rd_data` has 1-cycle latency: it reflects `rd_ch`/`rd_sel` and counter values registered at the edge where the select is sampled.
- Reset mid-RUN: everything returns to reset values immediately. No partial window is retained.
- Monitor inputs have no combinational path to any output.

## Test plan
- Single channel, burst: reset, start, 4-beat packet on ch0 with tkeep all-ones except last = 0x0F (512-bit), then stop.
  -> beats=4, pkts=1, bytes=196, stalls=0, cycles=4, state DONE.
- Backpressure: ch1 valid held 10 cycles with ready low for the first 3 and high for the last 7, tlast on the final beat.
  -> beats[1]=7, stalls[1]=3, cycles=7 (ARMED stall cycles are counted but do not start the window).
- Auto-stop: `pkt_target=2`, ch0 sends 3 single-beat packets, ch1 sends 2 later.
  -> pkts[0]=2 (third ignored), pkts[1]=2, `mon_done`=1 the cycle after ch1's second tlast, bitmap=0b11.
- Saturation: `CNT_W=8` build, ch0 streams 300 single-beat packets.
  -> beats=pkts=255, bytes=255.
- Priority: assert `ctrl_clear` and `ctrl_start` together in RUN.
  -> IDLE, all reads 0. Then `ctrl_start` with `ctrl_stop` in IDLE -> ARMED.
- Async reset mid-RUN with counters nonzero.
  -> `rd_data`, `mon_state`, `mon_done` read 0 before the next edge. Readback of sel 6 or `rd_ch=NUM_CH` -> 0.
